// File: rtl/biss_slave.sv
// ---------------------------------------------------------------------------
// biss_slave -- BiSS-C point-to-point slave (sensor side).
//
// A BiSS master toggles the MA line (biss_sck_i). The first falling edge
// of MA starts a frame: position and status are latched, and on each
// following MA rising edge one bit is driven on SLO (biss_dat_o):
//   Ack(0), Start(1), CDS(0), BITS position bits MSB first, nE, nW,
//   6 inverted CRC bits MSB first, then 0 while the line times out.
// MA must then stay high for TIMEOUT_CLKS clk_i cycles before SLO returns
// to 1 and a new frame may start. MA held high that long mid-frame is
// taken as a master abort.
//
// Parameters
//   TIMEOUT_CLKS : clk_i cycles MA must stay high to end/abort a frame
//   CRC_WIDTH    : CRC length; only 6 (x^6+x+1) is supported
//
// Ports
//   clk_i        : system clock, rising edge
//   reset_n_i    : asynchronous active-low reset
//   BITS         : position length (0 -> 1, >32 -> 32), latched per frame
//   posn_i       : right-justified position, latched per frame
//   nerr_i       : active-low error bit, latched per frame
//   nwrn_i       : active-low warning bit, latched per frame
//   biss_sck_i   : MA from the master, asynchronous to clk_i
//   crc_fault_i  : (BISS_SLAVE_CRC_FAULT_EN only) corrupt CRC LSB for the
//                  frame when 1 at frame start
//   biss_dat_o   : SLO to the master
//   busy_o       : high while a frame or its timeout is in progress
//   frame_done_o : one-cycle pulse when the last CRC bit is driven
//
// Build option
//   BISS_SLAVE_CRC_FAULT_EN : adds crc_fault_i for CRC error injection.
//
// Latency: SLO changes 3 clk_i cycles after the raw MA rising edge
// (2 synchroniser flops, then the output register).
// ---------------------------------------------------------------------------
module biss_slave #(
  parameter int TIMEOUT_CLKS = 2500,
  parameter int CRC_WIDTH    = 6
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  BITS,
  input  logic [31:0] posn_i,
  input  logic        nerr_i,
  input  logic        nwrn_i,
  input  logic        biss_sck_i,
`ifdef BISS_SLAVE_CRC_FAULT_EN
  input  logic        crc_fault_i,
`endif
  output logic        biss_dat_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int HW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [HW-1:0] HI_MAX = HW'(TIMEOUT_CLKS);
  // x^6 + x + 1 without the implicit x^6 term.
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = CRC_WIDTH'(3);
  localparam logic [5:0] CRC_LAST = 6'(CRC_WIDTH - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACK,
    ST_START,
    ST_CDS,
    ST_DATA,
    ST_NE,
    ST_NW,
    ST_CRC,
    ST_TIMEOUT
  } state_t;

  // Registered state
  state_t               state_q, state_d;
  logic                 s1_q, s1_d;     // synchroniser stage 1
  logic                 s2_q, s2_d;     // synchroniser stage 2 (safe copy)
  logic                 s3_q, s3_d;     // previous s2, for edge detect
  logic [HW-1:0]        hi_cnt_q, hi_cnt_d;
  logic [31:0]          shift_q, shift_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic                 nerr_q, nerr_d;
  logic                 nwrn_q, nwrn_d;
  logic                 dat_q, dat_d;
  logic                 done_q, done_d;
`ifdef BISS_SLAVE_CRC_FAULT_EN
  logic                 fault_q, fault_d;
`endif

  // Combinational helpers
  logic       ma_rise;
  logic       ma_fall;
  logic       ma_timeout;
  logic [5:0] bits_eff;
  logic [5:0] left_sh;
  logic       crc_bit;

  // Serial CRC step: feedback = in ^ msb, shift left, add poly on feedback.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0] crc,
    input logic                 din
  );
    logic fb;
    fb = din ^ crc[CRC_WIDTH-1];
    crc_step = {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  always_comb begin
    ma_rise    = s2_q & ~s3_q;
    ma_fall    = ~s2_q & s3_q;
    ma_timeout = (hi_cnt_q == HI_MAX);

    if (BITS == 8'd0) begin
      bits_eff = 6'd1;
    end else if (BITS > 8'd32) begin
      bits_eff = 6'd32;
    end else begin
      bits_eff = BITS[5:0];
    end
    // Left-justify the position so the next data bit is always shift_q[31].
    left_sh = 6'd32 - bits_eff;

    // CRC is sent inverted; the fault option flips the last bit only.
    crc_bit = ~crc_q[CRC_WIDTH-1];
`ifdef BISS_SLAVE_CRC_FAULT_EN
    if (fault_q && (bit_cnt_q == CRC_LAST)) begin
      crc_bit = ~crc_bit;
    end
`endif

    // Defaults: hold everything
    state_d   = state_q;
    s1_d      = biss_sck_i;
    s2_d      = s1_q;
    s3_d      = s2_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    crc_d     = crc_q;
    nerr_d    = nerr_q;
    nwrn_d    = nwrn_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
`ifdef BISS_SLAVE_CRC_FAULT_EN
    fault_d   = fault_q;
`endif

    // MA high-time counter: any low sample restarts it; it saturates.
    if (!s2_q) begin
      hi_cnt_d = '0;
    end else if (hi_cnt_q != HI_MAX) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end else begin
      hi_cnt_d = hi_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        dat_d = 1'b1;
        if (ma_fall) begin
          shift_d   = posn_i << left_sh;
          bit_cnt_d = bits_eff - 6'd1;
          nerr_d    = nerr_i;
          nwrn_d    = nwrn_i;
          crc_d     = '0;
`ifdef BISS_SLAVE_CRC_FAULT_EN
          fault_d   = crc_fault_i;
`endif
          state_d   = ST_ACK;
        end
      end

      // Falling edges here only reset the high-time counter.
      ST_TIMEOUT: begin
        dat_d = 1'b0;
        if (ma_timeout) begin
          dat_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        if (ma_timeout) begin
          // Master abort: drop the frame without a done pulse.
          dat_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ma_rise) begin
          case (state_q)
            ST_ACK: begin
              dat_d   = 1'b0;
              state_d = ST_START;
            end
            ST_START: begin
              dat_d   = 1'b1;
              state_d = ST_CDS;
            end
            ST_CDS: begin
              dat_d   = 1'b0;
              state_d = ST_DATA;
            end
            ST_DATA: begin
              dat_d   = shift_q[31];
              crc_d   = crc_step(crc_q, shift_q[31]);
              shift_d = {shift_q[30:0], 1'b0};
              if (bit_cnt_q == 6'd0) begin
                state_d = ST_NE;
              end else begin
                bit_cnt_d = bit_cnt_q - 6'd1;
              end
            end
            ST_NE: begin
              dat_d   = nerr_q;
              crc_d   = crc_step(crc_q, nerr_q);
              state_d = ST_NW;
            end
            ST_NW: begin
              dat_d     = nwrn_q;
              crc_d     = crc_step(crc_q, nwrn_q);
              bit_cnt_d = 6'd0;
              state_d   = ST_CRC;
            end
            ST_CRC: begin
              // bit_cnt counts CRC bits already sent; one extra rising
              // edge after the last drives the 0 that opens the timeout.
              if (bit_cnt_q <= CRC_LAST) begin
                dat_d     = crc_bit;
                crc_d     = {crc_q[CRC_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 6'd1;
                done_d    = (bit_cnt_q == CRC_LAST);
              end else begin
                dat_d   = 1'b0;
                state_d = ST_TIMEOUT;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      hi_cnt_q  <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      crc_q     <= '0;
      nerr_q    <= 1'b0;
      nwrn_q    <= 1'b0;
      dat_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef BISS_SLAVE_CRC_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      hi_cnt_q  <= hi_cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      crc_q     <= crc_d;
      nerr_q    <= nerr_d;
      nwrn_q    <= nwrn_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
`ifdef BISS_SLAVE_CRC_FAULT_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign biss_dat_o   = dat_q;
  assign frame_done_o = done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_biss_slave.sv
// ---------------------------------------------------------------------------
// tb_biss_slave -- directed bench for biss_slave.
// clk_i is 125 MHz (8 ns); MA is driven at 1 MHz (125 clk_i per period,
// low 62, high 63). SLO is sampled 10 clk_i after each MA rising edge.
// ---------------------------------------------------------------------------
module tb_biss_slave;

  // Clock / reset
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        reset_n;
  logic [7:0]  bits;
  logic [31:0] posn;
  logic        nerr;
  logic        nwrn;
  logic        sck;
  logic        fault;
  logic        dat;
  logic        busy;
  logic        done;

  biss_slave dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .BITS         (bits),
    .posn_i       (posn),
    .nerr_i       (nerr),
    .nwrn_i       (nwrn),
    .biss_sck_i   (sck),
`ifdef BISS_SLAVE_CRC_FAULT_EN
    .crc_fault_i  (fault),
`endif
    .biss_dat_o   (dat),
    .busy_o       (busy),
    .frame_done_o (done)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // Mid-frame input change, applied after the first falling edge.
  logic        chg_en = 1'b0;
  logic [31:0] chg_posn;
  logic [7:0]  chg_bits;

  always @(posedge clk) if (done) done_cnt++;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: returns the SLO bits seen on n MA rising edges,
  // right-justified, first bit most significant.
  task automatic exp_frame(input int b, input logic [31:0] p, input logic ne,
                           input logic nw, input logic flt,
                           output int n, output logic [63:0] v);
    int be;
    logic [5:0] crc;
    logic fb;
    logic [2:0] inb;
    be  = (b == 0) ? 1 : (b > 32) ? 32 : b;
    v   = '0;
    crc = '0;
    v = {v[60:0], 3'b010};
    for (int i = be - 1; i >= -2; i--) begin
      inb[0] = (i >= 0) ? p[i] : (i == -1) ? ne : nw;
      fb  = inb[0] ^ crc[5];
      crc = {crc[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
      v = {v[62:0], inb[0]};
    end
    for (int k = 5; k >= 0; k--) begin
      v = {v[62:0], ~crc[k] ^ (flt && (k == 0))};
    end
    v = {v[62:0], 1'b0};
    n = 3 + be + 2 + 6 + 1;
  endtask

  // Drive n MA pulses; collect SLO at each rising edge and AND of busy.
  task automatic run_frame(input int n, output logic [63:0] got, output logic busy_all);
    got = '0;
    busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      clks(62);
      if (i == 0 && chg_en) begin
        posn = chg_posn;
        bits = chg_bits;
      end
      sck = 1'b1;
      clks(10);
      got = {got[62:0], dat};
      busy_all = busy_all & busy;
      clks(53);
    end
  endtask

  task automatic full_frame(input string tag, input int b, input logic [31:0] p,
                            input logic ne, input logic nw);
    int n, d0;
    logic [63:0] v, got;
    logic ba;
    bits = 8'(b); posn = p; nerr = ne; nwrn = nw;
    exp_frame(b, p, ne, nw, 1'b0, n, v);
    d0 = done_cnt;
    run_frame(n, got, ba);
    chk({tag, "_bits"}, got, v);
    chk({tag, "_busy"}, 64'(ba), 64'd1);
    clks(2700);
    chk({tag, "_idle_slo"}, 64'(dat), 64'd1);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int n, d0;
    logic [63:0] v, got;
    logic ba;

    // Reset state
    reset_n = 1'b0; sck = 1'b1; bits = 8'd8; posn = '0;
    nerr = 1'b1; nwrn = 1'b1; fault = 1'b0;
    clks(5);
    chk("rst_slo", 64'(dat), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    clks(50);

    // BITS=8, posn=0: 0,1,0,00000000,1,1,111010 then 0; timeout details.
    d0 = done_cnt;
    run_frame(20, got, ba);
    chk("f8_bits", got, 64'(20'b010_00000000_11_111010_0));
    chk("f8_busy", 64'(ba), 64'd1);
    chk("f8_done", 64'(done_cnt - d0), 64'd1);
    clks(1400);
    chk("tmo_hold", 64'(dat), 64'd0);
    chk("tmo_busy", 64'(busy), 64'd1);
    sck = 1'b0;              // falling edge in TIMEOUT restarts the count
    clks(10);
    sck = 1'b1;
    clks(2000);
    chk("tmo_restart", 64'(dat), 64'd0);
    clks(700);
    chk("tmo_end_slo", 64'(dat), 64'd1);
    chk("tmo_end_busy", 64'(busy), 64'd0);
    chk("tmo_one_done", 64'(done_cnt - d0), 64'd1);

    // Full-width and status-bit patterns
    full_frame("f32", 32, 32'hA5A5A5A5, 1'b1, 1'b1);
    full_frame("f12_nerr", 12, 32'h00000ABC, 1'b0, 1'b1);

    // Master abort after 10 rising edges
    bits = 8'd8; posn = 32'h5A; nerr = 1'b1; nwrn = 1'b1;
    exp_frame(8, 32'h5A, 1'b1, 1'b1, 1'b0, n, v);
    d0 = done_cnt;
    run_frame(10, got, ba);
    chk("abort_bits", got, v >> (n - 10));
    clks(2700);
    chk("abort_slo", 64'(dat), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    full_frame("after_abort", 8, 32'h5A, 1'b1, 1'b1);

    // Reset in the middle of DATA (SLO is 0 there with posn=0)
    bits = 8'd8; posn = '0;
    run_frame(5, got, ba);
    chk("mid_data_bits", got, 64'(5'b01000));
    reset_n = 1'b0;
    #1;
    chk("midrst_slo", 64'(dat), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    clks(3);
    reset_n = 1'b1;
    clks(100);
    full_frame("after_rst", 8, 32'hC3, 1'b1, 1'b1);

    // Inputs changed mid-frame are ignored; BITS=40 clamps to 32
    chg_en = 1'b1; chg_posn = 32'h0; chg_bits = 8'd8;
    full_frame("latch_b40", 40, 32'hF0F01234, 1'b1, 1'b1);
    chg_en = 1'b0;

    // BITS=0 behaves as one data bit
    full_frame("bits0", 0, 32'h00000001, 1'b1, 1'b0);

`ifdef BISS_SLAVE_CRC_FAULT_EN
    bits = 8'd8; posn = '0; nerr = 1'b1; nwrn = 1'b1; fault = 1'b1;
    d0 = done_cnt;
    run_frame(20, got, ba);
    fault = 1'b0;
    chk("fault_bits", got, 64'(20'b010_00000000_11_111011_0));
    chk("fault_done", 64'(done_cnt - d0), 64'd1);
    clks(2700);
    chk("fault_idle", 64'(dat), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biss_slave.md
BISS_SLAVE -- requirements
Module: biss_slave

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 2500, meaning the clk_i cycles MA must stay high to end a frame or abort one (20 us at 125 MHz).
REQ-002 SHALL have parameter CRC_WIDTH, default 6, meaning the CRC length; only 6 (polynomial x^6+x+1) is supported.
REQ-003 SHALL have port clk_i, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port BITS, input, 8 bits: position length; 0 is treated as 1 and values above 32 as 32.
REQ-006 SHALL have port posn_i, input, 32 bits: position, right-justified, transmitted MSB first.
REQ-007 SHALL have ports nerr_i and nwrn_i, input, 1 bit each: active-low error and warning bits.
REQ-008 SHALL have port biss_sck_i, input, 1 bit: master clock MA, asynchronous to clk_i.
REQ-009 SHALL have port biss_dat_o, output, 1 bit: slave data SLO.
REQ-010 SHALL have port busy_o, output, 1 bit: high while state is not IDLE.
REQ-011 SHALL have port frame_done_o, output, 1 bit: one-clk pulse when the last CRC bit is driven.

Function
REQ-012 SHALL pass biss_sck_i through a 2-FF synchroniser and detect rising and falling edges on the synchronised copy.
REQ-013 SHALL use the states IDLE, ACK, START, CDS, DATA, NE, NW, CRC and TIMEOUT.
REQ-014 SHALL, in IDLE, drive biss_dat_o=1; on an MA falling edge it SHALL latch posn_i, BITS, nerr_i and nwrn_i, clear the CRC and enter ACK.
REQ-015 SHALL update biss_dat_o only on MA rising edges, 3 clk_i cycles after the raw edge (2 sync + 1 output register).
REQ-016 SHALL drive the following on successive MA rising edges: ACK=0, START=1, CDS=0, then BITS data bits MSB first, then nE, then nW, then 6 CRC bits MSB first; the next rising edge SHALL drive 0 and enter TIMEOUT.
REQ-017 SHALL compute the CRC serially over the data bits, nE and nW (feedback = bit XOR crc[5]; shift left; XOR 0x03 when feedback is 1), with initial value 0, and transmit it inverted.
REQ-018 SHALL, in TIMEOUT, hold biss_dat_o=0 until MA has been continuously high for TIMEOUT_CLKS cycles, then drive 1 and enter IDLE.
REQ-019 SHALL ignore MA falling edges during TIMEOUT; each falling edge only restarts the high-time counter.
REQ-020 SHALL treat MA held high for TIMEOUT_CLKS in any state from ACK to CRC as a master abort: it SHALL go to IDLE with biss_dat_o=1 and SHALL NOT pulse frame_done_o.
REQ-021 SHALL ignore changes on posn_i, BITS, nerr_i and nwrn_i mid-frame; the latched values apply until IDLE.
REQ-022 SHALL saturate the high-time counter at TIMEOUT_CLKS and never wrap.

Reset
REQ-023 SHALL, on reset_n_i low, immediately force state=IDLE, biss_dat_o=1, busy_o=0, frame_done_o=0, the CRC, counters and shift register to 0, and the synchronisers to 1.
REQ-024 SHALL sample biss_sck_i only after reset release; a reset mid-frame abandons the frame, and the next MA falling edge starts a new one.

Configuration
REQ-025 SHALL, when the macro BISS_SLAVE_CRC_FAULT_EN is defined, add input crc_fault_i (1 bit), sampled at frame start; if it is 1, the transmitted CRC LSB SHALL be inverted for that frame.
REQ-026 SHALL, without BISS_SLAVE_CRC_FAULT_EN, have no crc_fault_i port and always transmit the correct CRC.

Verification
REQ-027 SHALL cover: BITS=8, posn_i=0x00, nerr_i=1, nwrn_i=1, 20 MA pulses at 1 MHz -> SLO bits 0,1,0,00000000,1,1,111010 (CRC 0x3A), then 0 until MA high for 2500 clks, then 1; frame_done_o pulses once.
REQ-028 SHALL cover: BITS=32, posn_i=0xA5A5A5A5 -> data bits match MSB first and the CRC matches the serial reference model; busy_o is high from the first falling edge to the return to IDLE.
REQ-029 SHALL cover: MA stopped high after 10 rising edges for 2500 clks -> IDLE, SLO=1, no frame_done_o; the next frame is correct.
REQ-030 SHALL cover: reset_n_i pulsed low mid-DATA -> SLO=1 within the same cycle, busy_o=0; the next frame is correct.
REQ-031 SHALL cover: posn_i changed mid-frame -> the latched value is transmitted; BITS=0 -> 1 data bit; BITS=40 -> 32 data bits.
REQ-032 SHALL cover, with BISS_SLAVE_CRC_FAULT_EN defined and crc_fault_i=1 under REQ-027 stimulus -> CRC 111011 transmitted.
